tdm_demux: RTL and testbench

TDM_DEMUX -- requirements
Module: tdm_demux

---
 rtl/tdm_demux_pkg.sv | 21 ++
 rtl/tdm_slot_shifter.sv | 52 +++++
 rtl/tdm_demux.sv | 133 +++++++++++++
 tb/tb_tdm_demux.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM demultiplexer: FSM state encoding, default
// frame geometry and the channel index wrap helper.
package tdm_demux_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } tdm_state_e;

  localparam int TDM_N_CH_DEF   = 2;
  localparam int TDM_SLOT_W_DEF = 8;

  function automatic int next_ch(input int idx, input int n_ch);
    if (idx >= n_ch - 1) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/tdm_slot_shifter.sv
// Slot shift register plus bit counter. done is high while the next shifted
// bit is the last bit of the slot; word is the slot value including that bit.
module tdm_slot_shifter
  import tdm_demux_pkg::*;
#(
  parameter int SLOT_W = TDM_SLOT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         restart,
  input  logic                         shift,
  input  logic                         flush,
  input  logic                         bit_in,
  output logic [SLOT_W-1:0]            word,
  output logic [$clog2(SLOT_W+1)-1:0]  bit_cnt,
  output logic                         done
);

  localparam int CNT_W = $clog2(SLOT_W + 1);

  logic [SLOT_W-1:0] shift_r;
  logic [CNT_W-1:0]  cnt_r;

  assign word    = {shift_r[SLOT_W-2:0], bit_in};
  assign bit_cnt = cnt_r;
  assign done    = (cnt_r == CNT_W'(SLOT_W - 1));

  // Shift register and bit counter; restart loads the current bit as the slot MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= '0;
      cnt_r   <= '0;
    end else if (flush) begin
      shift_r <= '0;
      cnt_r   <= '0;
    end else if (restart) begin
      shift_r <= {{(SLOT_W-1){1'b0}}, bit_in};
      cnt_r   <= CNT_W'(1);
    end else if (shift) begin
      shift_r <= word;
      if (done) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: locks onto frame_sync, splits the serial line into
// per-channel words and flags framing violations.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int N_CH   = TDM_N_CH_DEF,
  parameter int SLOT_W = TDM_SLOT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     line_in,
  input  logic                     slot_en,
  input  logic                     frame_sync,
  output logic [N_CH*SLOT_W-1:0]   ch_data,
  output logic [N_CH-1:0]          ch_valid,
  output logic                     frame_done,
  output logic                     sync_err,
  output logic                     locked
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int CNT_W = $clog2(SLOT_W + 1);

  tdm_state_e        state_r;
  tdm_state_e        state_nxt_s;
  logic [IDX_W-1:0]  ch_idx_r;
  logic [IDX_W-1:0]  ch_idx_nxt_s;
  logic              sh_restart_s;
  logic              sh_shift_s;
  logic              sh_flush_s;
  logic              sh_done_s;
  logic [SLOT_W-1:0] word_s;
  logic [CNT_W-1:0]  bit_cnt_s;
  logic              err_nxt_s;
  logic              at_boundary_s;
  logic              slot_done_s;
  logic              last_ch_s;

  tdm_slot_shifter #(
    .SLOT_W (SLOT_W)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (sh_restart_s),
    .shift   (sh_shift_s),
    .flush   (sh_flush_s),
    .bit_in  (line_in),
    .word    (word_s),
    .bit_cnt (bit_cnt_s),
    .done    (sh_done_s)
  );

  assign at_boundary_s = (ch_idx_r == '0) && (bit_cnt_s == '0);
  assign slot_done_s   = sh_shift_s && sh_done_s;
  assign last_ch_s     = (ch_idx_r == IDX_W'(N_CH - 1));

  // Next-state and shifter control for each sampled bit.
  always_comb begin
    state_nxt_s  = state_r;
    ch_idx_nxt_s = ch_idx_r;
    sh_restart_s = 1'b0;
    sh_shift_s   = 1'b0;
    sh_flush_s   = 1'b0;
    err_nxt_s    = 1'b0;
    if (slot_en) begin
      case (state_r)
        HUNT: begin
          if (frame_sync) begin
            state_nxt_s  = RECV;
            ch_idx_nxt_s = '0;
            sh_restart_s = 1'b1;
          end else begin
            state_nxt_s = HUNT;
          end
        end
        RECV: begin
          if (at_boundary_s && !frame_sync) begin
            // A frame must open with frame_sync; drop lock and the bit.
            err_nxt_s   = 1'b1;
            state_nxt_s = HUNT;
            sh_flush_s  = 1'b1;
          end else if (frame_sync) begin
            // Sync mid-frame is an error, but the bit still starts a new frame.
            err_nxt_s    = !at_boundary_s;
            ch_idx_nxt_s = '0;
            sh_restart_s = 1'b1;
          end else begin
            sh_shift_s = 1'b1;
            if (sh_done_s) begin
              ch_idx_nxt_s = IDX_W'(next_ch(int'(ch_idx_r), N_CH));
            end else begin
              ch_idx_nxt_s = ch_idx_r;
            end
          end
        end
        default: begin
          state_nxt_s = HUNT;
          sh_flush_s  = 1'b1;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, channel index and registered outputs; pulses clear every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= HUNT;
      ch_idx_r   <= '0;
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ch_idx_r   <= ch_idx_nxt_s;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= err_nxt_s;
      locked     <= (state_nxt_s == RECV);
      if (slot_done_s) begin
        ch_data[int'(ch_idx_r)*SLOT_W +: SLOT_W] <= word_s;
        ch_valid[ch_idx_r]                       <= 1'b1;
        frame_done                               <= last_ch_s;
      end else begin
        ch_data <= ch_data;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux (N_CH=2, SLOT_W=8): directed frames push
// expected output events; a negedge monitor pops and compares them.
module tb_tdm_demux;

  logic        clk;
  logic        rst_n;
  logic        line_in;
  logic        slot_en;
  logic        frame_sync;
  logic [15:0] ch_data;
  logic [1:0]  ch_valid;
  logic        frame_done;
  logic        sync_err;
  logic        locked;

  typedef struct {
    logic [1:0]  v;
    logic        fd;
    logic        se;
    logic [15:0] d;
    logic        lk;
    int          gap;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  last_cyc = 0;

  tdm_demux #(.N_CH(2), .SLOT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_in    (line_in),
    .slot_en    (slot_en),
    .frame_sync (frame_sync),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] v, input logic fd, input logic se,
                      input logic [15:0] d, input logic lk, input int gap);
    ev_t e;
    e.v = v; e.fd = fd; e.se = se; e.d = d; e.lk = lk; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: any pulse is an output event, matched in order against the queue.
  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (rst_n && (ch_valid != 2'b00 || frame_done || sync_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {11'd0, ch_valid, frame_done, sync_err, ch_data, locked}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event", {11'd0, ch_valid, frame_done, sync_err, ch_data, locked},
              {11'd0, e.v, e.fd, e.se, e.d, e.lk});
        if (e.gap != 0) check("event_gap", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
    end
  end

  task automatic bit_cycle(input logic b, input logic fs, input logic en);
    line_in    = b;
    frame_sync = fs;
    slot_en    = en;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic fs0, input logic gaps);
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(w[i], fs0 && (i == 7), 1'b1);
      if (gaps) bit_cycle(~w[i], 1'b1, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; line_in = 1'b0; slot_en = 1'b0; frame_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ch_data", {16'd0, ch_data}, 32'd0);
    check("reset_pulses", {29'd0, ch_valid, frame_done | sync_err}, 32'd0);
    check("reset_locked", {31'd0, locked}, 32'd0);
    rst_n = 1'b1;

    // Hunting: bits without frame_sync are discarded.
    send_word(8'hFF, 1'b0, 1'b0);
    check("hunt_locked", {31'd0, locked}, 32'd0);

    // Single frame 0xA5 / 0x3C.
    push(2'b01, 1'b0, 1'b0, 16'h00A5, 1'b1, 0);
    send_word(8'hA5, 1'b1, 1'b0);
    push(2'b10, 1'b1, 1'b0, 16'h3CA5, 1'b1, 8);
    send_word(8'h3C, 1'b0, 1'b0);

    // Back-to-back frames.
    push(2'b01, 1'b0, 1'b0, 16'h3C11, 1'b1, 8);
    send_word(8'h11, 1'b1, 1'b0);
    push(2'b10, 1'b1, 1'b0, 16'h2211, 1'b1, 8);
    send_word(8'h22, 1'b0, 1'b0);
    push(2'b01, 1'b0, 1'b0, 16'h2233, 1'b1, 8);
    send_word(8'h33, 1'b1, 1'b0);
    push(2'b10, 1'b1, 1'b0, 16'h4433, 1'b1, 8);
    send_word(8'h44, 1'b0, 1'b0);
    check("b2b_locked", {31'd0, locked}, 32'd1);

    // Missing frame_sync at the boundary.
    push(2'b00, 1'b0, 1'b1, 16'h4433, 1'b0, 1);
    bit_cycle(1'b1, 1'b0, 1'b1);
    send_word(8'hFF, 1'b0, 1'b0);
    check("lost_locked", {31'd0, locked}, 32'd0);
    check("lost_ch_data", {16'd0, ch_data}, 32'h4433);

    // frame_sync at bit 4 of channel 1 restarts a frame from that bit.
    push(2'b01, 1'b0, 1'b0, 16'h445A, 1'b1, 0);
    send_word(8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) bit_cycle(i[0], 1'b0, 1'b1);
    push(2'b00, 1'b0, 1'b1, 16'h445A, 1'b1, 5);
    push(2'b01, 1'b0, 1'b0, 16'h4496, 1'b1, 7);
    send_word(8'h96, 1'b1, 1'b0);
    push(2'b10, 1'b1, 1'b0, 16'h6996, 1'b1, 8);
    send_word(8'h69, 1'b0, 1'b0);

    // slot_en toggling: idle cycles carry junk that must be ignored.
    push(2'b01, 1'b0, 1'b0, 16'h69A5, 1'b1, 15);
    send_word(8'hA5, 1'b1, 1'b1);
    push(2'b10, 1'b1, 1'b0, 16'h3CA5, 1'b1, 16);
    send_word(8'h3C, 1'b0, 1'b1);

    // Reset at bit 5 of channel 0.
    for (int i = 0; i < 5; i++) bit_cycle(1'b1, i == 0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_ch_data", {16'd0, ch_data}, 32'd0);
    check("midrst_pulses", {29'd0, ch_valid, frame_done | sync_err}, 32'd0);
    check("midrst_locked", {31'd0, locked}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_word(8'hC3, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0);
    check("postrst_ch_data", {16'd0, ch_data}, 32'd0);
    check("postrst_locked", {31'd0, locked}, 32'd0);
    push(2'b01, 1'b0, 1'b0, 16'h0012, 1'b1, 0);
    send_word(8'h12, 1'b1, 1'b0);
    push(2'b10, 1'b1, 1'b0, 16'h3412, 1'b1, 8);
    send_word(8'h34, 1'b0, 1'b0);

    repeat (4) bit_cycle(1'b0, 1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
